// File: rtl/des_mmio_ctrl_if.sv
// Bus and engine-handshake bundle for the DES MMIO controller.
// slave  : the controller side (decodes the M-stage bus, drives the engine).
// master : the CPU/engine side (drives the bus, answers the engine handshake).
interface des_mmio_ctrl_if #(
    parameter int BLOCK_W = 64
);
    // M-stage data bus
    logic               memwrite_M;
    logic [31:0]        addr_M;
    logic [31:0]        writedata_M;
    logic [31:0]        readdata_out;
    logic               hit_M;

    // DES engine handshake
    logic               eng_start;
    logic               eng_mode;
    logic [BLOCK_W-1:0] eng_key;
    logic [BLOCK_W-1:0] eng_data;
    logic               eng_done;
    logic [BLOCK_W-1:0] eng_result;

    modport slave (
        input  memwrite_M, addr_M, writedata_M, eng_done, eng_result,
        output readdata_out, hit_M, eng_start, eng_mode, eng_key, eng_data
    );

    modport master (
        output memwrite_M, addr_M, writedata_M, eng_done, eng_result,
        input  readdata_out, hit_M, eng_start, eng_mode, eng_key, eng_data
    );
endinterface

// File: rtl/des_mmio_ctrl.sv
// DES coprocessor controller mapped into an 8-word window on the M-stage bus.
// Holds key/data, launches an external multi-cycle DES engine with a one-cycle
// start pulse, latches the result, and guards the wait with a timeout.
// Optional build macro DES_MMIO_IRQ_EN adds a registered irq output.
module des_mmio_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0080,
    parameter int          BLOCK_W     = 64,
    parameter int          TIMEOUT_CYC = 32,
    parameter int          CNT_W       = 8
) (
    input  logic           clk,
    input  logic           reset,
    des_mmio_ctrl_if.slave bus
`ifdef DES_MMIO_IRQ_EN
    ,
    output logic           irq
`endif
);
    localparam int HW = BLOCK_W / 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OFF_KEY_HI  = 3'd0,
        OFF_KEY_LO  = 3'd1,
        OFF_DATA_HI = 3'd2,
        OFF_DATA_LO = 3'd3,
        OFF_CTRL    = 3'd4,
        OFF_STATUS  = 3'd5,
        OFF_RES_HI  = 3'd6,
        OFF_RES_LO  = 3'd7
    } offset_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [HW-1:0]      r_key_hi;
    logic [HW-1:0]      r_key_lo;
    logic [HW-1:0]      r_data_hi;
    logic [HW-1:0]      r_data_lo;
    logic [BLOCK_W-1:0] r_res;
    logic               r_mode;
    logic               r_irq_en;
    logic               r_done;
    logic               r_timeout;
    logic               r_overrun;
    logic [CNT_W-1:0]   r_cnt;

    offset_t            w_off;
    logic               w_wr;
    logic               w_busy;
    logic               w_eng_start;
    logic               w_ctrl_wr;
    logic               w_start_wr;
    logic               w_status_wr;
    logic               w_drop_wr;
    logic               w_limit;
    logic               w_irq_en_nxt;
    logic               w_done_nxt;
    logic               w_timeout_nxt;
    logic               w_overrun_nxt;
    logic [31:0]        w_rdata;

    // Address decode: the low two address bits are don't-care (word accesses only).
    assign bus.hit_M   = (bus.addr_M[31:5] == BASE_ADDR[31:5]);
    assign w_off       = offset_t'(bus.addr_M[4:2]);
    assign w_wr        = bus.memwrite_M & bus.hit_M;
    assign w_ctrl_wr   = w_wr & (w_off == OFF_CTRL) & ~w_busy;
    assign w_start_wr  = w_ctrl_wr & bus.writedata_M[0];
    assign w_status_wr = w_wr & (w_off == OFF_STATUS);
    // Configuration writes that land while the engine is running are lost.
    assign w_drop_wr   = w_wr & w_busy & (w_off <= OFF_CTRL);
    assign w_limit     = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_irq_en_nxt = w_ctrl_wr ? bus.writedata_M[2] : r_irq_en;

    // FSM state register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state: an eng_done that coincides with the timeout limit wins.
    always_comb begin
        // NOTE: default assignment first so no path through the block leaves a latch.
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start_wr) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.eng_done)  w_state_nxt = S_DONE;
                else if (w_limit)  w_state_nxt = S_IDLE;
            end
            S_DONE:  w_state_nxt = w_start_wr ? S_ISSUE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: busy covers issue+wait; start is held low during reset.
    always_comb begin
        w_busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
        w_eng_start = (r_state == S_ISSUE) && !reset;
    end

    // Timeout counter: cleared in ISSUE, counts in WAIT, saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT) && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sticky flag next values: W1C first, then a same-cycle set overrides the clear.
    always_comb begin
        w_done_nxt    = r_done;
        w_timeout_nxt = r_timeout;
        w_overrun_nxt = r_overrun;
        if (w_status_wr) begin
            if (bus.writedata_M[1]) w_done_nxt    = 1'b0;
            if (bus.writedata_M[2]) w_timeout_nxt = 1'b0;
            if (bus.writedata_M[3]) w_overrun_nxt = 1'b0;
        end
        if (r_state == S_DONE)                              w_done_nxt    = 1'b1;
        if ((r_state == S_WAIT) && !bus.eng_done && w_limit) w_timeout_nxt = 1'b1;
        if (w_drop_wr)                                      w_overrun_nxt = 1'b1;
    end

    // Software-visible registers: key/data/ctrl writes only when idle, result from the engine.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_hi  <= '0;
            r_key_lo  <= '0;
            r_data_hi <= '0;
            r_data_lo <= '0;
            r_mode    <= 1'b0;
            r_irq_en  <= 1'b0;
            r_res     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr && !w_busy) begin
                unique case (w_off)
                    OFF_KEY_HI:  r_key_hi  <= HW'(bus.writedata_M);
                    OFF_KEY_LO:  r_key_lo  <= HW'(bus.writedata_M);
                    OFF_DATA_HI: r_data_hi <= HW'(bus.writedata_M);
                    OFF_DATA_LO: r_data_lo <= HW'(bus.writedata_M);
                    OFF_CTRL:    r_mode    <= bus.writedata_M[1];
                    default:     ;
                endcase
            end
            r_irq_en <= w_irq_en_nxt;
            if ((r_state == S_WAIT) && bus.eng_done) r_res <= bus.eng_result;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // Combinational readback; forced to zero while reset is asserted.
    always_comb begin
        w_rdata = '0;
        if (!reset) begin
            unique case (w_off)
                OFF_KEY_HI:  w_rdata = 32'(r_key_hi);
                OFF_KEY_LO:  w_rdata = 32'(r_key_lo);
                OFF_DATA_HI: w_rdata = 32'(r_data_hi);
                OFF_DATA_LO: w_rdata = 32'(r_data_lo);
                OFF_CTRL:    w_rdata = {29'b0, r_irq_en, r_mode, 1'b0};
                OFF_STATUS:  w_rdata = {28'b0, r_overrun, r_timeout, r_done, w_busy};
                OFF_RES_HI:  w_rdata = 32'(r_res[BLOCK_W-1:HW]);
                OFF_RES_LO:  w_rdata = 32'(r_res[HW-1:0]);
                default:     w_rdata = '0;
            endcase
        end
    end

    assign bus.readdata_out = w_rdata;
    assign bus.eng_start    = w_eng_start;
    assign bus.eng_mode     = r_mode;
    assign bus.eng_key      = {r_key_hi, r_key_lo};
    assign bus.eng_data     = {r_data_hi, r_data_lo};

`ifdef DES_MMIO_IRQ_EN
    logic r_irq;

    // Interrupt tracks the post-edge flags so it drops the cycle after the clearing W1C.
    always_ff @(posedge clk) begin
        if (reset) r_irq <= 1'b0;
        else       r_irq <= w_irq_en_nxt & (w_done_nxt | w_timeout_nxt);
    end

    assign irq = r_irq;
`endif

endmodule
